// File: rtl/prog_loader.sv
// prog_loader: instruction-memory program loader and CPU release sequencer.
//
// Holds the CPU in reset while a host streams instruction words into the
// instruction memory through a valid/ready handshake, then waits a fixed
// settle time before releasing the CPU. A new load may be requested while
// the CPU is running; the CPU is put back into reset first.
//
// Ports:
//   i_clk           clock, all state on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_load_start    one-cycle pulse: request a program load
//   i_run_start     one-cycle pulse: release the CPU without loading
//   i_load_len      words to load (1..16, 0 means 16), sampled at load start
//   i_in_valid      host word valid
//   i_in_data       host instruction word
//   o_in_ready      loader accepts i_in_data this cycle
//   o_prog_enable   instruction-memory mux select, 1 = loader owns memory
//   o_prog_we       instruction-memory write enable
//   o_prog_addr     instruction-memory write address
//   o_prog_data     instruction-memory write data
//   o_cpu_reset     CPU reset, active-high
//   o_busy          high while loading or settling
//   o_done          one-cycle pulse on entry to RUN
module prog_loader #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal 1..15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load_start,
  input  logic       i_run_start,
  input  logic [4:0] i_load_len,
  input  logic       i_in_valid,
  input  logic [7:0] i_in_data,
  output logic       o_in_ready,
  output logic       o_prog_enable,
  output logic       o_prog_we,
  output logic [3:0] o_prog_addr,
  output logic [7:0] o_prog_data,
  output logic       o_cpu_reset,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    StHold,
    StLoad,
    StDrain,
    StSettle,
    StRun
  } state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [4:0] r_len;     // words to accept in this load, 1..16
  logic [4:0] r_cnt;     // words accepted so far
  logic [3:0] r_addr;
  logic [7:0] r_data;
  logic       r_we;
  logic [3:0] r_settle;
  logic       r_done;

  logic       w_ready;
  logic       w_hs;
  logic       w_load_entry;
  logic [4:0] w_len_eff;

  assign w_ready = (r_state == StLoad) && (r_cnt < r_len);
  assign w_hs    = i_in_valid && w_ready;

  // Zero encodes a full 16-word load; out-of-range lengths saturate to 16 so
  // the address can never run past the memory.
  assign w_len_eff = ((i_load_len == 5'd0) || (i_load_len > 5'd16)) ? 5'd16 : i_load_len;

  assign w_load_entry = (w_state_next == StLoad) && (r_state != StLoad);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StHold: begin
        if (i_load_start) begin
          w_state_next = StLoad;  // load wins over run_start
        end else if (i_run_start) begin
          w_state_next = StSettle;
        end
      end
      StLoad: begin
        if (w_hs && ((r_cnt + 5'd1) == r_len)) begin
          w_state_next = StDrain;
        end
      end
      // One cycle to let the final registered write reach memory.
      StDrain:  w_state_next = StSettle;
      StSettle: begin
        if (r_settle == SettleLast) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (i_load_start) begin
          w_state_next = StLoad;
        end
      end
      default: w_state_next = StHold;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StHold;
      r_len    <= 5'd0;
      r_cnt    <= 5'd0;
      r_addr   <= 4'd0;
      r_data   <= 8'd0;
      r_we     <= 1'b0;
      r_settle <= 4'd0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_we    <= w_hs;
      if (w_load_entry) begin
        r_len  <= w_len_eff;
        r_cnt  <= 5'd0;
        r_addr <= 4'd0;
      end else if (w_hs) begin
        // Address of the write happening next cycle is the index of this word.
        r_cnt  <= r_cnt + 5'd1;
        r_addr <= r_cnt[3:0];
        r_data <= i_in_data;
      end
      r_settle <= (r_state == StSettle) ? (r_settle + 4'd1) : 4'd0;
      r_done   <= (w_state_next == StRun) && (r_state != StRun);
    end
  end

  assign o_in_ready    = w_ready;
  assign o_prog_enable = (r_state == StLoad) || (r_state == StDrain);
  assign o_prog_we     = r_we;
  assign o_prog_addr   = r_addr;
  assign o_prog_data   = r_data;
  assign o_cpu_reset   = (r_state != StRun);
  assign o_busy        = (r_state == StLoad) || (r_state == StSettle);
  assign o_done        = r_done;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles cpu_reset stays asserted after load completes; legal 1..15.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load_start  input  1  one-cycle pulse requesting a program load.
REQ-005 run_start  input  1  one-cycle pulse requesting CPU release without loading.
REQ-006 load_len  input  5  number of instruction words to load, 1..16; sampled when load_start is accepted.
REQ-007 in_valid  input  1  host word valid.
REQ-008 in_data  input  8  host instruction word (opcode + operand, instruction_t layout).
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 prog_enable  output  1  instruction-memory address mux select, 1 = loader owns memory.
REQ-011 prog_we  output  1  instruction-memory write enable.
REQ-012 prog_addr  output  4  instruction-memory write address.
REQ-013 prog_data  output  8  instruction-memory write data.
REQ-014 cpu_reset  output  1  CPU reset, active-high.
REQ-015 busy  output  1  high in LOAD or SETTLE.
REQ-016 done  output  1  one-cycle pulse on entry to RUN.

Function
REQ-017 FSM states SHALL be HOLD, LOAD, DRAIN, SETTLE, RUN.
REQ-018 HOLD: cpu_reset=1, prog_enable=0, in_ready=0; load_start -> LOAD; run_start -> SETTLE; both same cycle -> LOAD (load wins).
REQ-019 On LOAD entry, word counter SHALL clear to 0, prog_addr SHALL be 0, length register SHALL capture load_len; load_len=0 SHALL be treated as 16.
REQ-020 LOAD: prog_enable=1, cpu_reset=1, in_ready=1 while accepted count < length.
REQ-021 Handshake = in_valid && in_ready; on handshake at edge N, prog_data SHALL take in_data and prog_we SHALL be 1 for the cycle after edge N with prog_addr = word index.
REQ-022 Back-to-back handshakes SHALL be supported: one word per cycle, prog_addr increments by 1 after each write cycle, no bubbles inserted.
REQ-023 prog_addr SHALL wrap 4'hF -> 4'h0 only via LOAD re-entry; a 16-word load ends with last write at address 4'hF.
REQ-024 When accepted count reaches length, in_ready SHALL drop next cycle and FSM SHALL go to DRAIN; DRAIN holds prog_enable=1 for exactly the final write cycle, then -> SETTLE.
REQ-025 prog_we SHALL never be 1 outside LOAD/DRAIN; prog_enable SHALL be 1 in every cycle prog_we is 1.
REQ-026 SETTLE: prog_enable=0, cpu_reset=1, counter runs SETTLE_CYCLES cycles, then -> RUN.
REQ-027 RUN: cpu_reset=0, prog_enable=0, done=1 for the first RUN cycle only.
REQ-028 load_start in RUN SHALL reassert cpu_reset the next cycle and enter LOAD (reload while CPU executing).
REQ-029 load_start or run_start in LOAD, DRAIN or SETTLE SHALL be ignored; run_start in RUN ignored.
REQ-030 in_valid with in_ready=0 SHALL not be consumed; in_data ignored outside handshake.

Reset
REQ-031 reset_n=0 SHALL immediately force: state HOLD, cpu_reset=1, prog_enable=0, prog_we=0, prog_addr=0, prog_data=0, in_ready=0, busy=0, done=0, counters 0.
REQ-032 Reset mid-LOAD SHALL abort without a further write; words already written remain in memory.
REQ-033 After reset_n deasserts, FSM SHALL stay in HOLD until load_start or run_start.

Verification
REQ-034 Reset, load_start with load_len=10, 10 consecutive valid words 0x20..0x29 -> prog_we pulses at addr 0..9 with those data, SETTLE 2 cycles, cpu_reset falls, done pulses once.
REQ-035 load_len=0, 16 words with in_valid toggling every other cycle -> 16 writes addr 0..F, no write while in_valid=0, in_ready drops after 16th.
REQ-036 In RUN, pulse load_start, load 3 words -> cpu_reset=1 next cycle, writes at addr 0..2, CPU released after SETTLE.
REQ-037 Assert reset_n=0 after 4th of 8 words -> all outputs at reset values same cycle, no write at addr 4, HOLD afterwards.
REQ-038 load_start and run_start same cycle in HOLD -> LOAD entered; run_start in LOAD -> no effect on write sequence.
REQ-039 Directed SVA: prog_we implies prog_enable and cpu_reset; done never high two consecutive cycles.
